mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative multiply/divide unit for the EX stage. It accepts MULT/MULTU/DIV/DIVU requests and computes the 64-bit result over one or more cycles. Completion is signalled with a single-cycle write strobe plus HI/LO data, which drive the HI/LO register file's write port. A busy output stalls the pipeline while an operation is in flight.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  request valid; sampled only in IDLE.
- op_i  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- opa_i  in  WIDTH  rs operand (multiplicand or dividend).
- opb_i  in  WIDTH  rt operand (multiplier or divisor).
- cancel_i  in  1  flush; aborts any in-flight operation.
- busy_o  out  1  high in every state except IDLE.
- wrn_hilo_o  out  1  one-cycle HI/LO write strobe.
- hi_o  out  WIDTH  upper product, or remainder.
- lo_o  out  WIDTH  lower product, or quotient.

## Operation
- States: IDLE, MUL, DIV, DONE.
- IDLE, start_i=1, cancel_i=0:
  - Latch op_i.
  - Latch operand magnitudes; for signed ops, take the absolute value of each operand.
  - Latch result-sign flags:
    - quotient/product negative = sign(a) XOR sign(b);
    - remainder negative = sign(a).
  - Next state: MUL for MULT/MULTU, DIV for DIV/DIVU.
- DIV with opb_i==0: go directly to DONE with hi=opa_i and lo=0xFFFFFFFF. This applies to both signed and unsigned division.
- DIV state, restoring radix-2 division:
  - 32 iterations, one quotient bit per cycle, MSB first.
  - A 6-bit counter runs 0..31; after count 31, go to DONE.
- MUL state: see Configuration.
- DONE:
  - Apply sign fix-up (two's-complement negate where the flag is set).
  - Register hi_o and lo_o.
  - wrn_hilo_o=1 for this cycle only.
  - Next state: IDLE.
- Arithmetic:
  - Multiply yields a 64-bit result: hi=[63:32], lo=[31:0].
  - Quotient truncates toward zero.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0. No trap.
- start_i outside IDLE is ignored; the issuing stage holds the instruction while busy_o=1.
- hi_o and lo_o hold their last values and change only on entering DONE.

## Timing
- Reset values: state=IDLE, busy_o=0, wrn_hilo_o=0, hi_o=0, lo_o=0, counter=0.
- rst has priority over everything.
- Latency, with the request accepted at edge N:
  - DIV/DIVU: busy_o=1 in cycles N+1..N+33; strobe at N+33.
  - Divide by zero: strobe at N+1.
  - MULT/MULTU: see Configuration.
- cancel_i:
  - In any non-IDLE state, including DONE: next state is IDLE and there is no strobe.
  - hi_o and lo_o are unchanged.
  - In IDLE, cancel_i suppresses acceptance of a simultaneous start_i.
- rst mid-operation: IDLE next cycle, no strobe, outputs return to reset values.
- Back-to-back ops: the earliest next acceptance is the cycle after DONE (in IDLE).
- busy_o is decoded combinationally from state.

## Configuration
- MULDIV_ITER_MUL_EN defined:
  - Multiply is shift-add on magnitudes, one bit per cycle.
  - MUL lasts 32 cycles, sharing the division counter.
  - Strobe at N+33; busy N+1..N+33.
- Not defined:
  - A single-cycle WIDTH×WIDTH multiply is registered in MUL.
  - MUL lasts 1 cycle, DONE follows.
  - Strobe at N+2; busy N+1..N+2.
- Results must be bit-identical in both configurations.

## Structure
- Shared defines/package holds:
  - op encodings: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - state encodings;
  - the iteration count constant (32).
- One sub-module: div_iter.
  - Contains the restoring-divider datapath: remainder/quotient shift registers and one conditional subtract per cycle.
  - Exposes load, step and result ports.
  - The FSM, sign handling and multiply stay in mul_div_unit.

## Test plan
- MULT opa=0xFFFFFFFE, opb=3 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; exactly one strobe at the configured latency.
- MULTU opa=opb=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV opa=0xFFFFFFF9 (−7), opb=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; busy N+1..N+33; strobe at N+33.
- DIVU 100/7 → lo=14, hi=2.
- DIV opa=5, opb=0 → hi=5, lo=0xFFFFFFFF, strobe at N+1.
- DIV started, cancel_i at N+10 → IDLE at N+11, no strobe, hi/lo unchanged. A new DIVU 9/3 is then accepted and yields lo=3, hi=0.

Source files
------------

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: operation
// encodings, FSM states and the iteration count of the iterative paths.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10,
    DONE = 2'b11
  } md_state_e;

  // One quotient (or multiplier) bit per cycle.
  localparam int unsigned MD_ITER_COUNT = 32;

  function automatic logic op_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/result bundle between the issuing EX stage and the mul/div unit.
//
// Handshake: the issuer raises start_i with op_i/opa_i/opb_i; the unit takes
// it on the first rising edge where it is idle (busy_o=0) and cancel_i=0,
// and ignores start_i while busy_o=1 (the issuer holds the instruction).
// Completion is a single-cycle wrn_hilo_o pulse with hi_o/lo_o valid in the
// same cycle. cancel_i aborts any in-flight operation without a write.
interface mul_div_unit_if #(parameter int WIDTH = 32);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] opa_i;
  logic [WIDTH-1:0] opb_i;
  logic             cancel_i;
  logic             busy_o;
  logic             wrn_hilo_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output start_i, op_i, opa_i, opb_i, cancel_i,
    input  busy_o, wrn_hilo_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i, cancel_i,
    output busy_o, wrn_hilo_o, hi_o, lo_o
  );
endinterface

// File: rtl/mul_div_unit_div_iter.sv
// Restoring radix-2 divider datapath on unsigned magnitudes. The quotient
// register starts as the dividend and shifts quotient bits in at the LSB.
// quo_o/rem_o present the values *after* the current step so the caller can
// capture the final result on the same edge as the last step.
module mul_div_unit_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [WIDTH:0]   partial;
  logic             fits;

  // Shift in the next dividend bit and test whether the divisor fits.
  assign partial = {rem_q, quo_q[WIDTH-1]};
  assign fits    = (partial >= {1'b0, dvsr_q});
  assign quo_o   = {quo_q[WIDTH-2:0], fits};
  assign rem_o   = fits ? WIDTH'(partial - {1'b0, dvsr_q}) : partial[WIDTH-1:0];

  // Load operands or advance one conditional-subtract step.
  always_comb begin
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    if (load_i) begin
      rem_d  = '0;
      quo_d  = dividend_i;
      dvsr_d = divisor_i;
    end else if (step_i) begin
      rem_d = rem_o;
      quo_d = quo_o;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
    end
  end
endmodule

// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit for MULT/MULTU/DIV/DIVU. Signed operations
// work on magnitudes and fix the sign up when the result is written.
// Build option MULDIV_ITER_MUL_EN: multiply by 32-cycle shift-add instead of
// a single-cycle array multiply; results are identical either way.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  mul_div_unit_if.slave    md,
  output md_state_e        dbg_state_o
);
  localparam logic [5:0] CNT_LAST = 6'(MD_ITER_COUNT - 1);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d, op_in;
  logic [5:0]         cnt_q, cnt_d;
  logic               neg_q, neg_d, rem_neg_q, rem_neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               sa, sb, div_load, div_step;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in, quo_nx, rem_nx, quo_fix, rem_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Operand magnitudes straight from the request.
  assign op_in    = md_op_e'(md.op_i);
  assign sa       = op_is_signed(op_in) & md.opa_i[WIDTH-1];
  assign sb       = op_is_signed(op_in) & md.opb_i[WIDTH-1];
  assign mag_a_in = sa ? -md.opa_i : md.opa_i;
  assign mag_b_in = sb ? -md.opb_i : md.opb_i;

  mul_div_unit_div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (div_load),
    .step_i     (div_step),
    .dividend_i (mag_a_in),
    .divisor_i  (mag_b_in),
    .quo_o      (quo_nx),
    .rem_o      (rem_nx)
  );

`ifdef MULDIV_ITER_MUL_EN
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     psum;
  // Shift-add: multiplier sits in the low half and is consumed LSB first.
  assign psum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod = {psum, prod_q[WIDTH-1:1]};
`else
  logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  assign prod = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};
`endif

  // Sign fix-up of whichever result is completing this cycle.
  assign prod_fix = (op_is_signed(op_q) & neg_q) ? -prod : prod;
  assign quo_fix  = (op_is_signed(op_q) & neg_q) ? -quo_nx : quo_nx;
  assign rem_fix  = (op_is_signed(op_q) & rem_neg_q) ? -rem_nx : rem_nx;
  assign res_hi   = op_q[1] ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo   = op_q[1] ? quo_fix : prod_fix[WIDTH-1:0];

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_load  = 1'b0;
    div_step  = 1'b0;
`ifdef MULDIV_ITER_MUL_EN
    mcand_d   = mcand_q;
    prod_d    = prod_q;
`else
    mag_a_d   = mag_a_q;
    mag_b_d   = mag_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (md.start_i && !md.cancel_i) begin
          op_d      = op_in;
          neg_d     = sa ^ sb;
          rem_neg_d = sa;
          cnt_d     = '0;
`ifdef MULDIV_ITER_MUL_EN
          mcand_d   = mag_a_in;
          prod_d    = {{WIDTH{1'b0}}, mag_b_in};
`else
          mag_a_d   = mag_a_in;
          mag_b_d   = mag_b_in;
`endif
          if (!op_in[1]) begin
            state_d = MUL;
          end else if (md.opb_i == '0) begin
            // Divide by zero: no iterations, fixed result.
            state_d = DONE;
            hi_d    = md.opa_i;
            lo_d    = '1;
          end else begin
            state_d  = DIV;
            div_load = 1'b1;
          end
        end
      end
      MUL: begin
        if (md.cancel_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
`ifdef MULDIV_ITER_MUL_EN
          prod_d = prod;
          cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
`else
          state_d = DONE;
          hi_d    = res_hi;
          lo_d    = res_lo;
`endif
        end
      end
      DIV: begin
        if (md.cancel_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          div_step = 1'b1;
          cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + 6'd1;
          if (cnt_q == CNT_LAST) begin
            state_d = DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; rst wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_ITER_MUL_EN
      mcand_q   <= '0;
      prod_q    <= '0;
`else
      mag_a_q   <= '0;
      mag_b_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_ITER_MUL_EN
      mcand_q   <= mcand_d;
      prod_q    <= prod_d;
`else
      mag_a_q   <= mag_a_d;
      mag_b_q   <= mag_b_d;
`endif
    end
  end

  // A cancel arriving in DONE suppresses the write.
  assign md.busy_o     = (state_q != IDLE);
  assign md.wrn_hilo_o = (state_q == DONE) && !md.cancel_i;
  assign md.hi_o       = hi_q;
  assign md.lo_o       = lo_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed vector table, hand-written cancel and
// reset sequences, then random operations against an arithmetic model.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_ITER_MUL_EN
  localparam int MUL_LAT = 33;
`else
  localparam int MUL_LAT = 2;
`endif
  localparam int DIV_LAT = 33;
  localparam int TIMEOUT = 80;

  typedef struct {
    md_op_e      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic      clk = 1'b0;
  logic      rst;
  md_state_e dbg_state;
  int        n_pass = 0;
  int        n_total = 0;
  int        strobe_cnt = 0;

  mul_div_unit_if #(.WIDTH(W)) md();

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .md          (md),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && md.wrn_hilo_o === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference: plain signed/unsigned arithmetic on 64-bit values.
  function automatic logic [63:0] ref_model(md_op_e op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, q, rm;
    logic [63:0] r;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    case (op)
      MD_MULT:  r = sa * sb;
      MD_MULTU: r = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else if (op == MD_DIV) begin
          q  = sa / sb;
          rm = sa % sb;
          r  = {rm[31:0], q[31:0]};
        end else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  function automatic int ref_lat(md_op_e op, logic [31:0] b);
    if (op == MD_MULT || op == MD_MULTU) return MUL_LAT;
    if (b == 32'd0) return 1;
    return DIV_LAT;
  endfunction

  // ---------------- driver tasks ----------------
  // Present a request while idle; returns 1 time unit after the accepting edge.
  task automatic start_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
    int w;
    w = 0;
    while (md.busy_o !== 1'b0 && w < TIMEOUT) begin
      @(negedge clk);
      w++;
    end
    if (w >= TIMEOUT) check("idle_wait", 64'(md.busy_o), 64'd0);
    md.start_i = 1'b1;
    md.op_i    = op;
    md.opa_i   = a;
    md.opb_i   = b;
    @(posedge clk);
    #1;
    md.start_i = 1'b0;
  endtask

  // Count cycles to the strobe; busy must be high up to and including it,
  // and the unit must be idle with no strobe the cycle after.
  task automatic wait_done(output logic [63:0] res, output int lat, output bit busy_ok);
    busy_ok = 1'b1;
    lat     = -1;
    res     = '0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      @(negedge clk);
      if (md.busy_o !== 1'b1) busy_ok = 1'b0;
      if (md.wrn_hilo_o === 1'b1) begin
        lat = k;
        res = {md.hi_o, md.lo_o};
        break;
      end
    end
    @(negedge clk);
    if (md.busy_o !== 1'b0 || md.wrn_hilo_o !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic run_and_check(input string name, input md_op_e op, input logic [31:0] a,
                               input logic [31:0] b, input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int          lat;
    bit          bok;
    start_op(op, a, b);
    wait_done(res, lat, bok);
    check({name, "_hilo"}, res, exp);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy"}, 64'(bok), 64'd1);
  endtask

  // ---------------- test ----------------
  vec_t vecs[12];

  initial begin
    int          s0;
    md_op_e      op;
    logic [31:0] a, b;

    vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
    vecs[3]  = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT};
    vecs[4]  = '{MD_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    vecs[5]  = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1};
    vecs[6]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, DIV_LAT};
    vecs[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         MUL_LAT};
    vecs[8]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_LAT};
    vecs[9]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, MUL_LAT};
    vecs[10] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, DIV_LAT};
    vecs[11] = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1};

    // Reset.
    rst         = 1'b1;
    md.start_i  = 1'b0;
    md.cancel_i = 1'b0;
    md.op_i     = 2'b00;
    md.opa_i    = '0;
    md.opb_i    = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  64'(md.busy_o), 64'd0);
    check("rst_wrn",   64'(md.wrn_hilo_o), 64'd0);
    check("rst_hilo",  {md.hi_o, md.lo_o}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));

    // Directed vectors, issued back to back.
    for (int i = 0; i < 12; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                    {vecs[i].hi, vecs[i].lo}, vecs[i].lat);

    // Cancel mid-divide: no strobe, hi/lo keep the previous result.
    run_and_check("pre_cancel", MD_MULTU, 32'd6, 32'd7, 64'd42, MUL_LAT);
    s0 = strobe_cnt;
    start_op(MD_DIV, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 md.cancel_i = 1'b1;
    @(posedge clk);
    #1 md.cancel_i = 1'b0;
    @(negedge clk);
    check("cancel_busy",  64'(md.busy_o), 64'd0);
    check("cancel_state", 64'(dbg_state), 64'(IDLE));
    repeat (40) @(negedge clk);
    check("cancel_strobes", 64'(strobe_cnt), 64'(s0));
    check("cancel_hilo", {md.hi_o, md.lo_o}, 64'd42);
    run_and_check("after_cancel", MD_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, DIV_LAT);

    // Cancel during DONE (divide by zero): the write is suppressed.
    s0 = strobe_cnt;
    start_op(MD_DIV, 32'd5, 32'd0);
    md.cancel_i = 1'b1;
    @(negedge clk);
    check("cancel_done_wrn", 64'(md.wrn_hilo_o), 64'd0);
    @(posedge clk);
    #1 md.cancel_i = 1'b0;
    @(negedge clk);
    check("cancel_done_busy", 64'(md.busy_o), 64'd0);
    check("cancel_done_strobes", 64'(strobe_cnt), 64'(s0));

    // Cancel in IDLE blocks a simultaneous start.
    md.start_i  = 1'b1;
    md.op_i     = MD_DIVU;
    md.opa_i    = 32'd50;
    md.opb_i    = 32'd5;
    md.cancel_i = 1'b1;
    @(posedge clk);
    #1;
    md.start_i  = 1'b0;
    md.cancel_i = 1'b0;
    @(negedge clk);
    check("idle_cancel_busy", 64'(md.busy_o), 64'd0);

    // Reset in the middle of a divide.
    run_and_check("pre_rst", MD_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, DIV_LAT);
    s0 = strobe_cnt;
    start_op(MD_DIVU, 32'd1000, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_busy",  64'(md.busy_o), 64'd0);
    check("midrst_hilo",  {md.hi_o, md.lo_o}, 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(IDLE));
    repeat (40) @(negedge clk);
    check("midrst_strobes", 64'(strobe_cnt), 64'(s0));

    // Random operations against the model.
    for (int i = 0; i < 40; i++) begin
      op = md_op_e'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       a = $urandom_range(0, 1000);
        3:       b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_and_check($sformatf("rand%0d", i), op, a, b, ref_model(op, a, b), ref_lat(op, b));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
